// File: rtl/sync_fifo_pkg.sv
// Shared FIFO constants and helpers, reused by all FIFO variants in the block.
package fifo_pkg;
    localparam int DEF_DATA_WIDTH = 4;
    localparam int DEF_ADDR_WIDTH = 3;

    // The occupancy counter needs one extra bit so that it can hold the value DEPTH.
    function automatic int cnt_width(input int addr_width);
        return addr_width + 1;
    endfunction
endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer-facing FIFO bus. The master drives requests, and the slave is the FIFO.
interface sync_fifo_if import fifo_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) ();
    logic                               wen;
    logic [DATA_WIDTH-1:0]              wdata;
    logic                               ren;
    logic                               clr_err;
    logic [DATA_WIDTH-1:0]              rdata;
    logic                               rvalid;
    logic                               full;
    logic                               empty;
    logic                               almost_full;
    logic                               almost_empty;
    logic [cnt_width(ADDR_WIDTH)-1:0]   count;
    logic                               overflow;
    logic                               underflow;

    modport master (
        output wen, wdata, ren, clr_err,
        input  rdata, rvalid, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
    modport slave (
        input  wen, wdata, ren, clr_err,
        output rdata, rvalid, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage with one write port and a registered, read-enabled read port.
// Only the output register is reset. The array contents are never reset.
module fifo_ram #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // A read and a write to the same slot in one cycle return the old word.
    always_ff @(posedge clk) begin
        if (rst)       rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, occupancy count, threshold flags and sticky errors.
module sync_fifo import fifo_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int AFULL_LVL  = (2**ADDR_WIDTH) - 1,
    parameter int AEMPTY_LVL = 1
) (
    input  logic      clk,
    input  logic      rst,
    sync_fifo_if.slave bus
);
    localparam int CW = cnt_width(ADDR_WIDTH);
    localparam logic [CW-1:0] DEPTH_C  = CW'(2**ADDR_WIDTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LVL);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LVL);

    logic [ADDR_WIDTH:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                full_q, empty_q, afull_q, aempty_q;
    logic                ovf_q, ovf_d, unf_q, unf_d;
    logic                rvalid_q;
    logic                wacc, racc;

    always_comb begin
        racc    = bus.ren & ~empty_q;
        wacc    = bus.wen & (~full_q | racc);
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wacc) wptr_d = wptr_q + 1'b1;
        if (racc) rptr_d = rptr_q + 1'b1;
        case ({wacc, racc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A set condition takes priority over a clear in the same cycle.
        ovf_d = (bus.wen & ~wacc) | (ovf_q & ~bus.clr_err);
        unf_d = (bus.ren & ~racc) | (unf_q & ~bus.clr_err);
    end

    // The flags come from next-state count, so they line up with count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == DEPTH_C);
            empty_q  <= (count_d == '0);
            afull_q  <= (count_d >= AFULL_C);
            aempty_q <= (count_d <= AEMPTY_C);
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            rvalid_q <= racc;
        end
    end

    fifo_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wacc & ~rst),
        .waddr_i (wptr_q[ADDR_WIDTH-1:0]),
        .wdata_i (bus.wdata),
        .re_i    (racc & ~rst),
        .raddr_i (rptr_q[ADDR_WIDTH-1:0]),
        .rdata_o (bus.rdata)
    );

    assign bus.rvalid       = rvalid_q;
    assign bus.count        = count_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = afull_q;
    assign bus.almost_empty = aempty_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
endmodule
